mc_controller_ext: RTL and testbench
====================================

Name: mc_controller_ext

Overview:
Multicycle RV32I control unit, the next generation of the course controller. It drives the shared-memory multicycle datapath: PC/IR/memory/register-file enables, ALU operand muxes, ALU operation, immediate format and result mux. Beyond the base lw/sw/R/I-ALU/beq/jal/lui set it adds:
- all six branches, jalr, auipc, xor/sltu/shifts;
- a memory ready/stall handshake;
- an illegal-opcode trap state.

Parameters:
STALL_EN, 1, 1: honour mem_ready_i in Fetch/MemRead/MemWrite; 0: mem_ready_i treated as constant 1.
RV32I_EXT, 1, 1: enable bne/blt/bge/bltu/bgeu, jalr, auipc, xor, sltu, sll/srl/sra; 0: those opcodes are illegal, non-base funct3 decodes to add/not-taken.
ILLEGAL_TRAP, 1, 1: unknown opcode enters Trap; 0: unknown opcode returns to Fetch (NOP).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
op_i  in  7  instruction opcode
funct3_i  in  3  instruction funct3
funct7b5_i  in  1  instruction bit 30
zero_i  in  1  ALU result == 0
lt_i  in  1  signed rs1<rs2 from ALU subtract
ltu_i  in  1  unsigned rs1<rs2
mem_ready_i  in  1  memory completes access this cycle
PCWrite_o  out  1  PC load enable
MemReq_o  out  1  memory access request
MemWrite_o  out  1  memory write
IRWrite_o  out  1  IR/OldPC load enable
RegWrite_o  out  1  register file write
ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB_o  out  2  00 rs2, 01 imm, 10 const 4
AdrSrc_o  out  1  0 PC, 1 ALUOut
ResultSrc_o  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUControl_o  out  4  operation code
ImmSrc_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal_o  out  1  high while in Trap
state_o  out  4  current state (debug)

Behaviour:
- States, 4-bit encoding:
  - Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5
  - ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, Branch 10, LUI 11
  - JALR 12, Trap 13, Reset 15
- Outputs are Moore and registered: the control vector is computed from state_next and loaded with state each edge, so signals are valid in the cycle the state is current.
- Exceptions to registered outputs:
  - PCWrite_o is combinational.
  - IRWrite_o and PCUpdate are gated by mem_ready_i.
  - ALUControl_o is combinational from registered ALUOp and funct3_i/funct7b5_i/op_i[5].
  - ImmSrc_o is combinational from op_i.
- Reset: on an edge with reset=1, state goes to Reset and all registered controls go to 0. ALUOp resets to add, so ALUControl_o=0000. illegal_o=0.
  - Reset to Fetch unconditionally.
  - Reset asserted mid-instruction aborts it; no write enable is active in the Reset state.
- Transitions:
  - Fetch: stays while !mem_ready_i; otherwise Decode.
  - Decode:
    - lw/sw→MemAdr
    - R→ExecuteR
    - I-ALU→ExecuteI
    - branch→Branch
    - jal→JAL
    - lui→LUI
    - jalr→JALR
    - auipc→ALUWB
    - other→Trap, or Fetch if ILLEGAL_TRAP=0
  - MemAdr: lw→MemRead, sw→MemWrite.
  - MemRead: stays while !mem_ready_i, then MemWB.
  - MemWrite: stays while !mem_ready_i, then Fetch.
  - ExecuteR/ExecuteI/JAL→ALUWB.
  - JALR→JAL.
  - MemWB/ALUWB/Branch/LUI→Fetch.
  - Trap: self-loop until reset.
- Control vectors (unlisted controls = 0):
  - Fetch: MemReq=1, IRWrite, PCUpdate, A=PC, B=4, Result=10, add.
  - Decode: A=OldPC, B=imm, add; for auipc this latches PC+immU.
  - MemAdr: A=rs1, B=imm, add.
  - MemRead: MemReq=1, AdrSrc=1.
  - MemWrite: MemReq=1, MemWrite=1, AdrSrc=1.
  - MemWB: RegWrite, Result=01.
  - ExecuteR: A=rs1, B=rs2, ALUOp=other.
  - ExecuteI: A=rs1, B=imm, ALUOp=other.
  - ALUWB: RegWrite, Result=00.
  - JALR: A=rs1, B=imm, add.
  - JAL: PCUpdate, A=OldPC, B=4, Result=00, add.
  - Branch: Branch, A=rs1, B=rs2, Result=00, sub.
  - LUI: RegWrite, Result=11.
- MemWrite_o stays high through all stall cycles. The write commits on the cycle mem_ready_i=1.
- PCWrite_o = PCUpdate | (Branch & take).
- take by funct3: 000 zero_i; 001 !zero_i; 100 lt_i; 101 !lt_i; 110 ltu_i; 111 !ltu_i; 010/011 → 0. With RV32I_EXT=0, only 000 can be taken.
- ALUControl codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001.
- ALUOp=other decodes by funct3:
  - 000: sub only if op_i[5]&funct7b5_i, else add
  - 001 sll, 010 slt, 011 sltu, 100 xor
  - 101: sra if funct7b5_i, else srl (both R and I)
  - 110 or, 111 and
- Unmapped decodes, including RV32I_EXT=0 extensions, give add.

Test Plan:
- Reset held 3 cycles, then released with mem_ready_i=1 → state_o 15 then 0; first Fetch cycle has IRWrite_o=1, PCWrite_o=1, MemReq_o=1; all outputs 0 during Reset.
- lw (op 0000011) with mem_ready_i low 2 cycles in Fetch and 3 in MemRead → state sequence 0,0,0,1,2,3,3,3,3,4,0; IRWrite_o high only on the ready Fetch cycle; RegWrite_o=1 and ResultSrc_o=01 in MemWB.
- bltu (funct3 110) with ltu_i=1, then bgeu with ltu_i=1 → PCWrite_o=1 in Branch state for the first, 0 for the second; ALUControl_o=0001 in both.
- jalr (1100111) → states 1,12,9,7,0; JALR: ALUSrcA_o=10, ALUSrcB_o=01; JAL: PCWrite_o=1, Result=00; ALUWB: RegWrite_o=1.
- srai (0010011, funct3 101, funct7b5 1) → ALUControl_o=1001 in ExecuteI; addi with funct7b5=1 → 0000 (no sub for I-type).
- Opcode 1111111 → Trap; illegal_o=1 and no write enable for 10 cycles; reset recovers. With ILLEGAL_TRAP=0, it returns to Fetch after Decode.

Source files
------------

// File: rtl/mc_controller_ext.sv
// Multicycle RV32I control unit: sequences the shared-memory datapath through
// fetch/decode/execute/writeback with a memory-ready stall and an illegal-opcode trap.
module mc_controller_ext #(
  parameter bit STALL_EN     = 1'b1,
  parameter bit RV32I_EXT    = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       MemReq_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       AdrSrc_o,
  output logic [1:0] ResultSrc_o,
  output logic [3:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_JALR     = 4'd12,
    S_TRAP     = 4'd13,
    S_RESET    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OTHER = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       memreq;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   rdy;
  logic   take;
  state_t bad_op_dest;

  assign rdy         = mem_ready_i | !STALL_EN;
  assign bad_op_dest = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

  // State and control vector load together, so controls match the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          OP_JALR:      state_d = RV32I_EXT ? S_JALR : bad_op_dest;
          OP_AUIPC:     state_d = RV32I_EXT ? S_ALUWB : bad_op_dest;
          default:      state_d = bad_op_dest;
        endcase
      end
      S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (rdy) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:             state_d = S_ALUWB;
      S_JALR:                              state_d = S_JAL;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI:   state_d = S_FETCH;
      S_TRAP:                              state_d = S_TRAP;
      default:                             state_d = S_FETCH;
    endcase
  end

  // Control vector for the state about to become current.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.memreq    = 1'b1;
        ctrl_d.irwrite   = 1'b1;
        ctrl_d.pcupdate  = 1'b1;
        ctrl_d.alusrcb   = 2'b10;
        ctrl_d.resultsrc = 2'b10;
      end
      S_DECODE: begin
        ctrl_d.alusrca = 2'b01;
        ctrl_d.alusrcb = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        ctrl_d.alusrca = 2'b10;
        ctrl_d.alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        ctrl_d.memreq = 1'b1;
        ctrl_d.adrsrc = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_d.memreq   = 1'b1;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.adrsrc   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.regwrite  = 1'b1;
        ctrl_d.resultsrc = 2'b01;
      end
      S_EXECR: begin
        ctrl_d.alusrca = 2'b10;
        ctrl_d.aluop   = ALUOP_OTHER;
      end
      S_EXECI: begin
        ctrl_d.alusrca = 2'b10;
        ctrl_d.alusrcb = 2'b01;
        ctrl_d.aluop   = ALUOP_OTHER;
      end
      S_ALUWB:  ctrl_d.regwrite = 1'b1;
      S_JAL: begin
        ctrl_d.pcupdate = 1'b1;
        ctrl_d.alusrca  = 2'b01;
        ctrl_d.alusrcb  = 2'b10;
      end
      S_BRANCH: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alusrca = 2'b10;
        ctrl_d.aluop   = ALUOP_SUB;
      end
      S_LUI: begin
        ctrl_d.regwrite  = 1'b1;
        ctrl_d.resultsrc = 2'b11;
      end
      S_TRAP:   ctrl_d.illegal = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (funct3_i)
      3'b000:  take = zero_i;
      3'b001:  take = RV32I_EXT & !zero_i;
      3'b100:  take = RV32I_EXT & lt_i;
      3'b101:  take = RV32I_EXT & !lt_i;
      3'b110:  take = RV32I_EXT & ltu_i;
      3'b111:  take = RV32I_EXT & !ltu_i;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    ALUControl_o = ALU_ADD;
    case (ctrl_q.aluop)
      ALUOP_SUB: ALUControl_o = ALU_SUB;
      ALUOP_OTHER: begin
        case (funct3_i)
          3'b000:  ALUControl_o = (op_i[5] & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl_o = RV32I_EXT ? ALU_SLL : ALU_ADD;
          3'b010:  ALUControl_o = ALU_SLT;
          3'b011:  ALUControl_o = RV32I_EXT ? ALU_SLTU : ALU_ADD;
          3'b100:  ALUControl_o = RV32I_EXT ? ALU_XOR : ALU_ADD;
          3'b101:  ALUControl_o = RV32I_EXT ? (funct7b5_i ? ALU_SRA : ALU_SRL) : ALU_ADD;
          3'b110:  ALUControl_o = ALU_OR;
          default: ALUControl_o = ALU_AND;
        endcase
      end
      default: ALUControl_o = ALU_ADD;
    endcase
  end

  always_comb begin
    ImmSrc_o = 3'b000;
    case (op_i)
      OP_SW:            ImmSrc_o = 3'b001;
      OP_BR:            ImmSrc_o = 3'b010;
      OP_JAL:           ImmSrc_o = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc_o = 3'b100;
      default:          ImmSrc_o = 3'b000;
    endcase
  end

  // PC update only waits on memory when it rides along with a memory access (Fetch).
  assign PCWrite_o   = (ctrl_q.pcupdate & (rdy | !ctrl_q.memreq)) | (ctrl_q.branch & take);
  assign IRWrite_o   = ctrl_q.irwrite & rdy;
  assign MemReq_o    = ctrl_q.memreq;
  assign MemWrite_o  = ctrl_q.memwrite;
  assign RegWrite_o  = ctrl_q.regwrite;
  assign ALUSrcA_o   = ctrl_q.alusrca;
  assign ALUSrcB_o   = ctrl_q.alusrcb;
  assign AdrSrc_o    = ctrl_q.adrsrc;
  assign ResultSrc_o = ctrl_q.resultsrc;
  assign illegal_o   = ctrl_q.illegal;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Directed bench for mc_controller_ext: reset, stalled lw/sw, branches, jalr,
// ALU decode and illegal-opcode trap (trap and no-trap variants in lockstep).
module tb_mc_controller_ext;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;

  logic       pcw, mreq, mwr, irw, rwr, adr, ill;
  logic [1:0] srca, srcb, res;
  logic [3:0] aluc, st;
  logic [2:0] imm;

  logic       n_pcw, n_mreq, n_mwr, n_irw, n_rwr, n_adr, n_ill;
  logic [1:0] n_srca, n_srcb, n_res;
  logic [3:0] n_aluc, n_st;
  logic [2:0] n_imm;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  always #5 clk = ~clk;

  mc_controller_ext u_dut (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready),
    .PCWrite_o(pcw), .MemReq_o(mreq), .MemWrite_o(mwr), .IRWrite_o(irw),
    .RegWrite_o(rwr), .ALUSrcA_o(srca), .ALUSrcB_o(srcb), .AdrSrc_o(adr),
    .ResultSrc_o(res), .ALUControl_o(aluc), .ImmSrc_o(imm), .illegal_o(ill),
    .state_o(st)
  );

  mc_controller_ext #(.ILLEGAL_TRAP(1'b0)) u_nt (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready),
    .PCWrite_o(n_pcw), .MemReq_o(n_mreq), .MemWrite_o(n_mwr), .IRWrite_o(n_irw),
    .RegWrite_o(n_rwr), .ALUSrcA_o(n_srca), .ALUSrcB_o(n_srcb), .AdrSrc_o(n_adr),
    .ResultSrc_o(n_res), .ALUControl_o(n_aluc), .ImmSrc_o(n_imm), .illegal_o(n_ill),
    .state_o(n_st)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", 8'(st), 8'd15);
    chk("rst_state_nt", 8'(n_st), 8'd15);
    chk("rst_pcw", 8'(pcw), 8'd0);
    chk("rst_mreq", 8'(mreq), 8'd0);
    chk("rst_mwr", 8'(mwr), 8'd0);
    chk("rst_irw", 8'(irw), 8'd0);
    chk("rst_rwr", 8'(rwr), 8'd0);
    chk("rst_srca", 8'(srca), 8'd0);
    chk("rst_srcb", 8'(srcb), 8'd0);
    chk("rst_adr", 8'(adr), 8'd0);
    chk("rst_res", 8'(res), 8'd0);
    chk("rst_aluc", 8'(aluc), 8'd0);
    chk("rst_imm", 8'(imm), 8'd0);
    chk("rst_ill", 8'(ill), 8'd0);

    // release into a lui
    reset = 1'b0; op = OP_LUI;
    nc(); #1;
    chk("f0_state", 8'(st), 8'd0);
    chk("f0_irw", 8'(irw), 8'd1);
    chk("f0_pcw", 8'(pcw), 8'd1);
    chk("f0_mreq", 8'(mreq), 8'd1);
    chk("f0_srcb", 8'(srcb), 8'd2);
    chk("f0_res", 8'(res), 8'd2);
    nc(); #1;
    chk("lui_dec_state", 8'(st), 8'd1);
    chk("lui_dec_imm", 8'(imm), 8'd4);
    chk("lui_dec_srca", 8'(srca), 8'd1);
    chk("lui_dec_srcb", 8'(srcb), 8'd1);
    nc(); #1;
    chk("lui_state", 8'(st), 8'd11);
    chk("lui_rwr", 8'(rwr), 8'd1);
    chk("lui_res", 8'(res), 8'd3);

    // lw: 2 stall cycles in Fetch, 3 in MemRead
    nc(); op = OP_LW; mem_ready = 1'b0; #1;
    chk("lw_f1_state", 8'(st), 8'd0);
    chk("lw_f1_irw", 8'(irw), 8'd0);
    chk("lw_f1_pcw", 8'(pcw), 8'd0);
    chk("lw_f1_mreq", 8'(mreq), 8'd1);
    nc(); #1;
    chk("lw_f2_state", 8'(st), 8'd0);
    chk("lw_f2_irw", 8'(irw), 8'd0);
    nc(); mem_ready = 1'b1; #1;
    chk("lw_f3_state", 8'(st), 8'd0);
    chk("lw_f3_irw", 8'(irw), 8'd1);
    chk("lw_f3_pcw", 8'(pcw), 8'd1);
    nc(); #1;
    chk("lw_dec_state", 8'(st), 8'd1);
    chk("lw_dec_irw", 8'(irw), 8'd0);
    nc(); #1;
    chk("lw_adr_state", 8'(st), 8'd2);
    chk("lw_adr_srca", 8'(srca), 8'd2);
    chk("lw_adr_srcb", 8'(srcb), 8'd1);
    nc(); mem_ready = 1'b0; #1;
    chk("lw_rd1_state", 8'(st), 8'd3);
    chk("lw_rd1_mreq", 8'(mreq), 8'd1);
    chk("lw_rd1_adr", 8'(adr), 8'd1);
    chk("lw_rd1_irw", 8'(irw), 8'd0);
    nc(); #1;
    chk("lw_rd2_state", 8'(st), 8'd3);
    nc(); #1;
    chk("lw_rd3_state", 8'(st), 8'd3);
    nc(); mem_ready = 1'b1; #1;
    chk("lw_rd4_state", 8'(st), 8'd3);
    chk("lw_rd4_irw", 8'(irw), 8'd0);
    nc(); #1;
    chk("lw_wb_state", 8'(st), 8'd4);
    chk("lw_wb_rwr", 8'(rwr), 8'd1);
    chk("lw_wb_res", 8'(res), 8'd1);

    // bltu taken
    nc(); op = OP_BR; funct3 = 3'b110; ltu = 1'b1; #1;
    chk("bltu_f_state", 8'(st), 8'd0);
    nc(); #1;
    chk("bltu_dec_imm", 8'(imm), 8'd2);
    nc(); #1;
    chk("bltu_state", 8'(st), 8'd10);
    chk("bltu_pcw", 8'(pcw), 8'd1);
    chk("bltu_aluc", 8'(aluc), 8'd1);
    chk("bltu_rwr", 8'(rwr), 8'd0);

    // bgeu not taken
    nc(); funct3 = 3'b111; #1;
    chk("bgeu_f_state", 8'(st), 8'd0);
    nc(); nc(); #1;
    chk("bgeu_state", 8'(st), 8'd10);
    chk("bgeu_pcw", 8'(pcw), 8'd0);
    chk("bgeu_aluc", 8'(aluc), 8'd1);

    // bne taken on nonzero
    nc(); funct3 = 3'b001; zero = 1'b0; #1;
    nc(); nc(); #1;
    chk("bne_pcw", 8'(pcw), 8'd1);

    // jalr
    nc(); op = OP_JALR; funct3 = 3'b000; ltu = 1'b0; #1;
    chk("jalr_f_state", 8'(st), 8'd0);
    nc(); #1;
    chk("jalr_dec_state", 8'(st), 8'd1);
    chk("jalr_dec_imm", 8'(imm), 8'd0);
    nc(); #1;
    chk("jalr_state", 8'(st), 8'd12);
    chk("jalr_srca", 8'(srca), 8'd2);
    chk("jalr_srcb", 8'(srcb), 8'd1);
    chk("jalr_pcw", 8'(pcw), 8'd0);
    nc(); #1;
    chk("jal_state", 8'(st), 8'd9);
    chk("jal_pcw", 8'(pcw), 8'd1);
    chk("jal_res", 8'(res), 8'd0);
    chk("jal_srca", 8'(srca), 8'd1);
    chk("jal_srcb", 8'(srcb), 8'd2);
    nc(); #1;
    chk("jalr_wb_state", 8'(st), 8'd7);
    chk("jalr_wb_rwr", 8'(rwr), 8'd1);

    // srai
    nc(); op = OP_I; funct3 = 3'b101; funct7b5 = 1'b1; #1;
    chk("srai_f_state", 8'(st), 8'd0);
    nc(); #1;
    chk("srai_dec_aluc", 8'(aluc), 8'd0);
    nc(); #1;
    chk("srai_state", 8'(st), 8'd8);
    chk("srai_aluc", 8'(aluc), 8'd9);
    nc(); #1;
    chk("srai_wb_state", 8'(st), 8'd7);

    // addi with bit30 set stays add
    nc(); funct3 = 3'b000; #1;
    nc(); nc(); #1;
    chk("addi_state", 8'(st), 8'd8);
    chk("addi_aluc", 8'(aluc), 8'd0);

    // R-type sub
    nc(); nc(); op = OP_R; #1;
    chk("sub_f_state", 8'(st), 8'd0);
    nc(); nc(); #1;
    chk("sub_state", 8'(st), 8'd6);
    chk("sub_aluc", 8'(aluc), 8'd1);
    chk("sub_srcb", 8'(srcb), 8'd0);

    // sw with one stall cycle
    nc(); nc(); op = OP_SW; funct7b5 = 1'b0; #1;
    chk("sw_f_state", 8'(st), 8'd0);
    nc(); #1;
    chk("sw_dec_imm", 8'(imm), 8'd1);
    nc(); #1;
    chk("sw_adr_state", 8'(st), 8'd2);
    nc(); mem_ready = 1'b0; #1;
    chk("sw_wr1_state", 8'(st), 8'd5);
    chk("sw_wr1_mwr", 8'(mwr), 8'd1);
    chk("sw_wr1_mreq", 8'(mreq), 8'd1);
    chk("sw_wr1_adr", 8'(adr), 8'd1);
    nc(); mem_ready = 1'b1; #1;
    chk("sw_wr2_state", 8'(st), 8'd5);
    chk("sw_wr2_mwr", 8'(mwr), 8'd1);

    // illegal opcode
    nc(); op = 7'h7F; #1;
    chk("ill_f_state", 8'(st), 8'd0);
    chk("ill_f_state_nt", 8'(n_st), 8'd0);
    nc(); #1;
    chk("ill_dec_state", 8'(st), 8'd1);
    chk("ill_dec_state_nt", 8'(n_st), 8'd1);
    nc(); #1;
    chk("nt_back_state", 8'(n_st), 8'd0);
    chk("nt_ill", 8'(n_ill), 8'd0);
    for (int i = 0; i < 10; i++) begin
      chk("trap_state", 8'(st), 8'd13);
      chk("trap_ill", 8'(ill), 8'd1);
      chk("trap_pcw", 8'(pcw), 8'd0);
      chk("trap_rwr", 8'(rwr), 8'd0);
      chk("trap_mwr", 8'(mwr), 8'd0);
      chk("trap_irw", 8'(irw), 8'd0);
      nc(); #1;
    end

    // reset recovers from trap
    reset = 1'b1; op = 7'd0;
    nc(); #1;
    chk("rec_rst_state", 8'(st), 8'd15);
    chk("rec_rst_ill", 8'(ill), 8'd0);
    chk("rec_rst_state_nt", 8'(n_st), 8'd15);
    reset = 1'b0;
    nc(); #1;
    chk("rec_f_state", 8'(st), 8'd0);
    chk("rec_f_irw", 8'(irw), 8'd1);
    chk("rec_f_state_nt", 8'(n_st), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
